// File: rtl/pipeline_pkg.sv
// Shared codes for the memory stage: sequencer stage codes, memory op codes,
// load/store width codes, the memory-stage FSM state type and store-lane helpers.
package pipeline_pkg;

  localparam logic [2:0] STAGE_IF = 3'b000;
  localparam logic [2:0] STAGE_ID = 3'b001;
  localparam logic [2:0] STAGE_EX = 3'b010;
  localparam logic [2:0] STAGE_MM = 3'b011;
  localparam logic [2:0] STAGE_WB = 3'b100;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;
  localparam logic [1:0] MEM_OP_RSVD  = 2'b11;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_REQ  = 2'b01,
    MS_WAIT = 2'b10,
    MS_DONE = 2'b11
  } mem_state_e;

  // sz is funct3[1:0]: 00 byte, 01 half, anything else a full word
  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load alignment: picks the addressed byte/half lane from the raw bus word
// and sign- or zero-extends it according to funct3. Purely combinational.
module load_extend
  import pipeline_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane select, then extension by load width/signedness
  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (addr_lo_i)
      2'b00:   byte_sel = raw_i[7:0];
      2'b01:   byte_sel = raw_i[15:8];
      2'b10:   byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    case (funct3_i)
      FUNCT3_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_BU: data_o = {24'h000000, byte_sel};
      FUNCT3_H:  data_o = {{16{half_sel[15]}}, half_sel};
      FUNCT3_HU: data_o = {16'h0000, half_sel};
      default:   data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage responder: when the sequencer sits in MM with a load/store,
// issues one valid/ready bus request, waits for the response (or times out),
// and stalls the sequencer until the access completes.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the
// bus and finish immediately with err_o.
//
//  state   | meaning
//  IDLE    | no access in flight, waiting for MM with a load/store
//  REQ     | request presented on the bus, waiting for req_ready_i
//  WAIT    | request accepted, waiting for rsp_valid_i or timeout
//  DONE    | access finished; holds off re-issue until stage leaves MM
module mem_stage_ctrl
  import pipeline_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        stage_i,
  input  logic [1:0]        mem_op_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [31:0]       req_wdata_o,
  output logic [3:0]        req_wstrb_o,
  input  logic              rsp_valid_i,
  input  logic [31:0]       rsp_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q, done_d, err_q, err_d;
  logic [31:0]       rdata_q;
  logic              load_done;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        funct3_q;
  logic              access, misalign, timeout_hit, capture;
  logic [31:0]       load_data;

  assign access = (stage_i == STAGE_MM) &&
                  ((mem_op_i == MEM_OP_LOAD) || (mem_op_i == MEM_OP_STORE));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  assign capture = (state_q == MS_IDLE) && access && !misalign;

  // next-state and completion-pulse decode
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_done = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (access) begin
          if (misalign) begin
            state_d = MS_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = MS_REQ;
          end
        end
      end
      MS_REQ: begin
        if (req_ready_i) state_d = MS_WAIT;
      end
      MS_WAIT: begin
        // a response arriving on the timeout cycle still wins
        if (rsp_valid_i) begin
          state_d   = MS_DONE;
          done_d    = 1'b1;
          load_done = !we_q;
        end else if (timeout_hit) begin
          state_d = MS_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        if (stage_i != STAGE_MM) state_d = MS_IDLE;
      end
    endcase
  end

  // state, status pulses and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (load_done) rdata_q <= load_data;
    end
  end

  // request fields latched once on issue, held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
    end else if (capture) begin
      we_q      <= (mem_op_i == MEM_OP_STORE);
      addr_q    <= {addr_i[ADDR_W-1:2], 2'b00};
      wdata_q   <= store_data(funct3_i[1:0], wdata_i);
      wstrb_q   <= (mem_op_i == MEM_OP_STORE) ? store_strb(funct3_i[1:0], addr_i[1:0]) : 4'h0;
      addr_lo_q <= addr_i[1:0];
      funct3_q  <= funct3_i;
    end
  end

  // wait-cycle counter, zero on every WAIT entry
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (state_q == MS_WAIT) cnt_q <= cnt_q + 1'b1;
    else cnt_q <= '0;
  end

  load_extend u_load_extend (
    .raw_i     (rsp_rdata_i),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  assign stall_o     = access && (state_q != MS_DONE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign req_valid_o = (state_q == MS_REQ);
  assign req_we_o    = we_q;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;
  assign req_wstrb_o = wstrb_q;

endmodule
